// File: rtl/tm_accumulator.sv
// Signed multiply-accumulate stage behind the TM tree multiplier: sums a group of products
// and presents the result with valid/ready. Define TM_ACC_SATURATE_EN to clamp on overflow.
module tm_accumulator #(
  parameter int PROD_W    = 64,
  parameter int ACC_W     = 72,
  parameter int MAX_TERMS = 256,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic [PROD_W-1:0] product,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic [ACC_W-1:0]  acc_out,
  output logic [CNT_W-1:0]  term_cnt,
  output logic              ovf,
  output logic              out_valid,
  input  logic              out_ready
);

  // Handshake: a transfer happens on a rising edge where valid && ready; the source holds
  // its payload and valid until then, and ready never depends on valid.

  localparam logic ST_ACC = 1'b0;
  localparam logic ST_OUT = 1'b1;

  localparam logic [ACC_W-1:0] ACC_MAX  = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN  = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_TERMS - 1);

  logic             state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [ACC_W-1:0] acc_out_q, acc_out_d;
  logic [CNT_W-1:0] term_cnt_q, term_cnt_d;

  logic [ACC_W-1:0] prod_ext;
  logic [ACC_W-1:0] sum_raw;
  logic [ACC_W-1:0] sum_next;
  logic [CNT_W-1:0] cnt_inc;
  logic             add_ovf;
  logic             beat;
  logic             group_end;

  assign in_ready  = (state_q == ST_ACC);
  assign out_valid = (state_q == ST_OUT);
  assign acc_out   = acc_out_q;
  assign term_cnt  = term_cnt_q;
  assign ovf       = ovf_q;

  assign prod_ext  = ACC_W'($signed(product));
  assign sum_raw   = acc_q + prod_ext;
  assign add_ovf   = (acc_q[ACC_W-1] == prod_ext[ACC_W-1]) &&
                     (sum_raw[ACC_W-1] != acc_q[ACC_W-1]);
  assign cnt_inc   = cnt_q + 1'b1;
  assign beat      = in_valid && in_ready;
  // MAX_TERMS closes the group so the counter can never wrap.
  assign group_end = beat && (in_last || (cnt_q == LAST_CNT));

`ifdef TM_ACC_SATURATE_EN
  // Overflow direction follows the common operand sign.
  assign sum_next = add_ovf ? (acc_q[ACC_W-1] ? ACC_MIN : ACC_MAX) : sum_raw;
`else
  assign sum_next = sum_raw;
`endif

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;
    acc_out_d  = acc_out_q;
    term_cnt_d = term_cnt_q;
    if (clr) begin
      state_d    = ST_ACC;
      acc_d      = '0;
      cnt_d      = '0;
      ovf_d      = 1'b0;
      acc_out_d  = '0;
      term_cnt_d = '0;
    end else if (state_q == ST_ACC) begin
      if (beat) begin
        acc_d = sum_next;
        cnt_d = cnt_inc;
        ovf_d = ovf_q | add_ovf;
        if (group_end) begin
          state_d    = ST_OUT;
          acc_out_d  = sum_next;
          term_cnt_d = cnt_inc;
        end
      end
    end else if (out_ready) begin
      state_d = ST_ACC;
      acc_d   = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_ACC;
      acc_q      <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      acc_out_q  <= '0;
      term_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      acc_out_q  <= acc_out_d;
      term_cnt_q <= term_cnt_d;
    end
  end

endmodule

// File: tb/tb_tm_accumulator.sv
// Bench for tm_accumulator: three instances (default, MAX_TERMS=4, ACC_W=64) each checked
// every cycle against an arithmetic model, plus hand-computed expectations.
module tb_tm_accumulator;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [63:0] product_a [3];
  logic        in_valid_a [3];
  logic        in_last_a [3];
  logic        out_ready_a [3];
  logic        clr_a [3];

  logic [71:0] acc0, acc1;
  logic [63:0] acc2;
  logic [15:0] tc0, tc1, tc2;
  logic        rdy0, rdy1, rdy2, ov0, ov1, ov2, ovf0, ovf1, ovf2;

  tm_accumulator u_dut0 (
    .clk(clk), .rst(rst), .clr(clr_a[0]), .product(product_a[0]), .in_valid(in_valid_a[0]),
    .in_last(in_last_a[0]), .in_ready(rdy0), .acc_out(acc0), .term_cnt(tc0), .ovf(ovf0),
    .out_valid(ov0), .out_ready(out_ready_a[0]));

  tm_accumulator #(.MAX_TERMS(4)) u_dut1 (
    .clk(clk), .rst(rst), .clr(clr_a[1]), .product(product_a[1]), .in_valid(in_valid_a[1]),
    .in_last(in_last_a[1]), .in_ready(rdy1), .acc_out(acc1), .term_cnt(tc1), .ovf(ovf1),
    .out_valid(ov1), .out_ready(out_ready_a[1]));

  tm_accumulator #(.ACC_W(64)) u_dut2 (
    .clk(clk), .rst(rst), .clr(clr_a[2]), .product(product_a[2]), .in_valid(in_valid_a[2]),
    .in_last(in_last_a[2]), .in_ready(rdy2), .acc_out(acc2), .term_cnt(tc2), .ovf(ovf2),
    .out_valid(ov2), .out_ready(out_ready_a[2]));

  int n_tests = 0;
  int n_fail  = 0;
  bit armed   = 1'b0;

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int aw(input int i);
    return (i == 2) ? 64 : 72;
  endfunction

  function automatic int mt(input int i);
    return (i == 1) ? 4 : 256;
  endfunction

  function automatic logic rdy(input int i);
    return (i == 0) ? rdy0 : (i == 1) ? rdy1 : rdy2;
  endfunction

  // Model: exact integer sum compared against the representable range of each instance.
  logic signed [79:0] m_acc [3];
  logic signed [79:0] m_out [3];
  int                 m_cnt [3];
  int                 m_tc [3];
  bit                 m_ovf [3];
  bit                 m_oovf [3];
  bit                 m_hold [3];
  logic signed [79:0] ex, mx, mn;

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst || clr_a[i]) begin
        m_acc[i] = '0; m_out[i] = '0; m_cnt[i] = 0; m_tc[i] = 0;
        m_ovf[i] = 1'b0; m_oovf[i] = 1'b0; m_hold[i] = 1'b0;
      end else if (m_hold[i]) begin
        if (out_ready_a[i]) begin
          m_hold[i] = 1'b0; m_acc[i] = '0; m_cnt[i] = 0; m_ovf[i] = 1'b0;
        end
      end else if (in_valid_a[i]) begin
        ex = m_acc[i] + 80'($signed(product_a[i]));
        mx = (80'sd1 <<< (aw(i) - 1)) - 80'sd1;
        mn = -mx - 80'sd1;
        if (ex > mx || ex < mn) begin
          m_ovf[i] = 1'b1;
`ifdef TM_ACC_SATURATE_EN
          ex = (ex > mx) ? mx : mn;
`else
          ex = (ex <<< (80 - aw(i))) >>> (80 - aw(i));
`endif
        end
        m_acc[i] = ex;
        m_cnt[i] = m_cnt[i] + 1;
        if (in_last_a[i] || m_cnt[i] == mt(i)) begin
          m_hold[i] = 1'b1; m_out[i] = ex; m_tc[i] = m_cnt[i]; m_oovf[i] = m_ovf[i];
        end
      end
    end
  end

  logic [79:0] a_acc [3];
  logic [79:0] a_tc [3];
  logic        a_rdy [3];
  logic        a_ov [3];
  logic        a_ovf [3];

  always @(negedge clk) begin
    if (armed) begin
      a_acc[0] = 80'($signed(acc0)); a_acc[1] = 80'($signed(acc1)); a_acc[2] = 80'($signed(acc2));
      a_tc[0] = 80'(tc0); a_tc[1] = 80'(tc1); a_tc[2] = 80'(tc2);
      a_rdy[0] = rdy0; a_rdy[1] = rdy1; a_rdy[2] = rdy2;
      a_ov[0] = ov0; a_ov[1] = ov1; a_ov[2] = ov2;
      a_ovf[0] = ovf0; a_ovf[1] = ovf1; a_ovf[2] = ovf2;
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("u%0d_in_ready", i), 80'(a_rdy[i]), 80'(!m_hold[i]));
        chk($sformatf("u%0d_out_valid", i), 80'(a_ov[i]), 80'(m_hold[i]));
        if (m_hold[i]) begin
          chk($sformatf("u%0d_acc_out", i), a_acc[i], m_out[i]);
          chk($sformatf("u%0d_term_cnt", i), a_tc[i], 80'(m_tc[i]));
          chk($sformatf("u%0d_ovf", i), 80'(a_ovf[i]), 80'(m_oovf[i]));
        end
      end
    end
  end

  // Offer one product and hold it until accepted; returns just after the accepting edge.
  task automatic beat(input int i, input logic [63:0] v, input logic last);
    int n;
    n = 0;
    @(negedge clk);
    product_a[i] = v; in_valid_a[i] = 1'b1; in_last_a[i] = last;
    while (!rdy(i) && n < 64) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("u%0d_beat_accept", i), 80'(rdy(i)), 80'd1);
    @(posedge clk);
  endtask

  task automatic idle(input int i);
    @(negedge clk);
    in_valid_a[i] = 1'b0; in_last_a[i] = 1'b0;
  endtask

  logic signed [79:0] exp_big;

  initial begin
    for (int i = 0; i < 3; i++) begin
      product_a[i] = '0; in_valid_a[i] = 1'b0; in_last_a[i] = 1'b0;
      out_ready_a[i] = 1'b0; clr_a[i] = 1'b0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_acc_out", 80'(acc0), 80'd0);
    chk("rst_term_cnt", 80'(tc0), 80'd0);
    chk("rst_ovf", 80'(ovf0), 80'd0);
    chk("rst_out_valid", 80'(ov0), 80'd0);
    chk("rst_in_ready", 80'(rdy0), 80'd1);
    rst = 1'b0;
    armed = 1'b1;

    // Three TM products forming one group.
    beat(0, 64'(-2000), 1'b0);
    beat(0, 64'(6300), 1'b0);
    beat(0, 64'(5200), 1'b1);
    idle(0);
    chk("g1_out_valid", 80'(ov0), 80'd1);
    chk("g1_acc_out", 80'($signed(acc0)), 80'h251C);
    chk("g1_term_cnt", 80'(tc0), 80'd3);
    chk("g1_ovf", 80'(ovf0), 80'd0);
    out_ready_a[0] = 1'b1;
    @(negedge clk);
    out_ready_a[0] = 1'b0;
    chk("g1_handoff_in_ready", 80'(rdy0), 80'd1);
    chk("g1_handoff_out_valid", 80'(ov0), 80'd0);

    // Result held under backpressure while a new product waits upstream.
    beat(0, 64'(-3250), 1'b0);
    beat(0, 64'(0), 1'b0);
    beat(0, 64'(98765), 1'b0);
    beat(0, 64'(-999000), 1'b1);
    @(negedge clk);
    product_a[0] = 64'(777); in_last_a[0] = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk("g2_hold_acc_out", 80'($signed(acc0)), 80'(-903485));
      chk("g2_hold_in_ready", 80'(rdy0), 80'd0);
      @(negedge clk);
    end
    in_valid_a[0] = 1'b0;
    chk("g2_term_cnt", 80'(tc0), 80'd4);
    out_ready_a[0] = 1'b1;
    @(negedge clk);
    out_ready_a[0] = 1'b0;

    // Forced end of group at MAX_TERMS = 4.
    for (int k = 0; k < 4; k++) beat(1, 64'(1000), 1'b0);
    idle(1);
    chk("max_first_valid", 80'(ov1), 80'd1);
    chk("max_first_acc", 80'($signed(acc1)), 80'd4000);
    chk("max_first_cnt", 80'(tc1), 80'd4);
    out_ready_a[1] = 1'b1;
    beat(1, 64'(1000), 1'b0);
    beat(1, 64'(1000), 1'b1);
    idle(1);
    chk("max_second_acc", 80'($signed(acc1)), 80'd2000);
    chk("max_second_cnt", 80'(tc1), 80'd2);
    @(negedge clk);
    out_ready_a[1] = 1'b0;

    // Signed overflow in a 64-bit accumulator; result left held for the reset check.
    beat(2, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0);
    beat(2, 64'd1, 1'b1);
    idle(2);
`ifdef TM_ACC_SATURATE_EN
    exp_big = 80'sh0000_7FFF_FFFF_FFFF_FFFF;
`else
    exp_big = 80'($signed(64'h8000_0000_0000_0000));
`endif
    chk("ovf_acc_out", 80'($signed(acc2)), exp_big);
    chk("ovf_flag", 80'(ovf2), 80'd1);

    // Flush drops the partial group and the simultaneous beat.
    beat(0, 64'(500), 1'b0);
    beat(0, 64'(700), 1'b0);
    @(negedge clk);
    clr_a[0] = 1'b1; product_a[0] = 64'(900); in_valid_a[0] = 1'b1; in_last_a[0] = 1'b0;
    chk("clr_in_ready", 80'(rdy0), 80'd1);
    @(negedge clk);
    clr_a[0] = 1'b0; in_valid_a[0] = 1'b0;
    chk("clr_out_valid", 80'(ov0), 80'd0);
    chk("clr_acc_out", 80'(acc0), 80'd0);
    chk("clr_term_cnt", 80'(tc0), 80'd0);
    repeat (2) @(negedge clk);
    beat(0, 64'(42), 1'b1);
    idle(0);
    chk("after_clr_valid", 80'(ov0), 80'd1);
    chk("after_clr_acc", 80'($signed(acc0)), 80'd42);
    chk("after_clr_cnt", 80'(tc0), 80'd1);

    // Reset while results are held.
    chk("pre_rst_hold", 80'(ov2), 80'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_out_out_valid", 80'(ov2), 80'd0);
    chk("rst_out_acc_out", 80'(acc2), 80'd0);
    chk("rst_out_ovf", 80'(ovf2), 80'd0);
    chk("rst_out_in_ready", 80'(rdy2), 80'd1);
    chk("rst_out_u0_valid", 80'(ov0), 80'd0);
    chk("rst_out_u0_acc", 80'(acc0), 80'd0);
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/tm_accumulator.md
Name: tm_accumulator

Overview:
- Sequential stage directly downstream of the 32x32 signed tree multiplier TM.
- Consumes TM's 64-bit signed product and accumulates a stream of products into a wide signed sum (dot-product / MAC use).
- Presents the finished sum with valid/ready handshakes on both sides, so TM output can be registered and drained by a consumer.

Parameters:
- PROD_W, 64, width of the signed product input; matches TM result width.
- ACC_W, 72, accumulator width; must be >= PROD_W; 8 guard bits by default.
- MAX_TERMS, 256, forced end-of-group after this many accepted products; range 1..65535.
- CNT_W, 16, width of the term counter and term_cnt output.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- clr  input  1  synchronous flush; discards partial or held result.
- product  input  PROD_W  signed product from TM.result.
- in_valid  input  1  product is valid this cycle.
- in_last  input  1  product is the last term of the group.
- in_ready  output  1  block accepts a product this cycle.
- acc_out  output  ACC_W  signed accumulated result.
- term_cnt  output  CNT_W  number of terms summed into acc_out.
- ovf  output  1  sticky signed-overflow flag for the group.
- out_valid  output  1  acc_out, term_cnt and ovf are valid.
- out_ready  input  1  consumer takes the result.

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst; all state changes on the rising edge of clk.
- Reset values: acc, acc_out, term_cnt = 0; ovf = 0; out_valid = 0; state = ACC; in_ready = 1.
- FSM states:
  - ACC: collecting terms; in_ready = 1, out_valid = 0.
  - OUT: holding a result; in_ready = 0, out_valid = 1.
- Beat: in_valid && in_ready. On a beat:
  - sum = acc + sign_extend(product to ACC_W).
  - cnt increments.
  - ovf sets if the add overflows signed ACC_W: operand signs equal and sum sign differs. ovf is sticky for the group.
- End of group: a beat with in_last = 1, or a beat with cnt == MAX_TERMS-1.
  - Next cycle: state = OUT, acc_out = final sum, term_cnt = cnt+1, ovf final.
  - Latency: exactly 1 cycle from the last accepted beat to out_valid = 1.
- OUT:
  - acc_out, term_cnt and ovf are held stable while out_valid = 1 and out_ready = 0.
  - When out_ready = 1: next cycle acc, cnt, ovf = 0; out_valid = 0; state = ACC.
  - No back-to-back accept in the handoff cycle; in_ready rises one cycle after the handoff (bubble allowed).
- in_valid is ignored while in_ready = 0. The upstream holds product and in_valid.
- clr = 1 in any state: next cycle acc, cnt, ovf, acc_out, term_cnt = 0; out_valid = 0; state = ACC.
  - clr has priority over a simultaneous beat and over out_ready.
  - A beat in the same cycle as clr is dropped; in_ready still reads 1 in that cycle.
- rst has priority over clr. rst mid-group or in OUT discards everything.
- MAX_TERMS = 1: every beat ends a group.
- Counter never wraps, because the group is forced to end at MAX_TERMS.
- term_cnt saturates only by construction; CNT_W must be able to hold MAX_TERMS.

Optional Feature:
- Macro: TM_ACC_SATURATE_EN.
- Defined:
  - On overflow, the sum clamps to the signed ACC_W maximum (positive overflow) or minimum (negative overflow).
  - The clamped value stays latched; further terms continue from the clamped value.
  - ovf is still set.
- Undefined: two's-complement wrap-around; ovf set.
- Port list identical in both builds.

Test Plan:
- Sequence: rst for 2 cycles, then beats -2000, 6300, 5200 (last on 3rd) from TM(50,-40), TM(90,70), TM(-80,-65) -> one cycle after the 3rd beat, out_valid = 1, acc_out = 9500 (0x251C), term_cnt = 3, ovf = 0. Then out_ready = 1 -> in_ready = 1 the next cycle.
- Beats -3250, 0, 98765, -999000 (last) with out_ready held 0 for 5 cycles -> acc_out = -903485 held stable, in_ready = 0 throughout, products offered during the hold are not consumed.
- MAX_TERMS = 4, 6 beats of 1000, no in_last -> first result 4000/term_cnt 4; after the handoff the remaining 2 beats plus in_last give 2000/term_cnt 2.
- ACC_W = 64, beats 0x7FFF_FFFF_FFFF_FFFF then 1 (last):
  - without TM_ACC_SATURATE_EN -> acc_out = 0x8000_0000_0000_0000, ovf = 1.
  - with TM_ACC_SATURATE_EN -> acc_out = 0x7FFF_FFFF_FFFF_FFFF, ovf = 1.
- Beats 500, 700, then clr asserted together with a beat of 900 -> next cycle acc = 0, out_valid = 0, no result emitted. A following single beat 42 with last -> acc_out = 42, term_cnt = 1.
- rst asserted while in OUT with out_valid = 1 -> next cycle out_valid = 0, acc_out = 0, ovf = 0, in_ready = 1.
